// File: rtl/uart_rx_module.sv
// 8N1 UART receiver feeding a circular byte FIFO that exposes up to N oldest
// bytes per cycle and accepts a multi-byte pop.
`timescale 1ns/1ps
module uart_rx_module #(
  parameter int boadrate = 115200,
  parameter int CLK_FREQ = 50_000_000,
  parameter int DEPTH    = 8,
  parameter int N        = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  output logic [N-1:0][7:0]        data_o,
  input  logic [$clog2(N+1)-1:0]   pop,
  output logic [$clog2(N+1)-1:0]   can_pop,
  output logic                     frame_err,
  output logic                     overflow
);

  localparam int BIT_CYC  = CLK_FREQ / boadrate;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CNT_W    = $clog2(BIT_CYC + 1);
  localparam int PW       = $clog2(N + 1);
  localparam int CW       = $clog2(DEPTH + 1);
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_CYC - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [AW:0]      DEPTH_W   = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0]    LAST_PTR  = AW'(DEPTH - 1);
  localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
  localparam logic [CW-1:0]    DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0]    N_C       = CW'(N);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  // ---------------------------------------------------------------- sync
  logic       rx_meta;
  logic       rx_s;
  logic       rx_prev;
  logic [1:0] sync_fill;

  // rx_prev stays 0 until the synchronizer holds real line samples, so a
  // line that is already low when reset drops never looks like a 1->0 edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b0;
      sync_fill <= 2'b00;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
      rx_prev   <= sync_fill[1] ? rx_s : 1'b0;
    end
  end

  // ---------------------------------------------------------------- fsm
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_reg, bit_next;
  logic [7:0]       shift_reg, shift_next;
  logic             wr_en;
  logic             stop_bad;
  logic             expired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  assign expired = (cnt_reg == '0);

  always_comb begin
    state_next = state_reg;
    cnt_next   = expired ? cnt_reg : cnt_reg - CNT_ONE;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    wr_en      = 1'b0;
    stop_bad   = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (rx_prev && !rx_s) begin
          state_next = START;
          cnt_next   = HALF_LOAD;
        end
      end
      START: begin
        if (expired) begin
          if (!rx_s) begin
            state_next = DATA;
            cnt_next   = BIT_LOAD;
            bit_next   = '0;
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
      end
      DATA: begin
        if (expired) begin
          shift_next = {rx_s, shift_reg[7:1]};
          cnt_next   = BIT_LOAD;
          if (bit_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end
      end
      STOP: begin
        if (expired) begin
          cnt_next = '0;
          if (rx_s) begin
            wr_en      = 1'b1;
            state_next = IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_next = '0;
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------- fifo
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, rd_ptr_next;
  logic [AW-1:0] wr_ptr, wr_ptr_next;
  logic [CW-1:0] count, count_next;
  logic [PW-1:0] eff_pop;
  logic [AW:0]   rd_sum;
  logic          accept;

  always_comb begin
    if (count >= N_C) begin
      can_pop = PW'(N);
    end else begin
      can_pop = PW'(count);
    end
    eff_pop = (pop > can_pop) ? can_pop : pop;
    // Space freed by this cycle's pop is usable by this cycle's write.
    accept  = wr_en && ((count - CW'(eff_pop)) < DEPTH_C);
    rd_sum  = {1'b0, rd_ptr} + (AW + 1)'(eff_pop);
    if (rd_sum >= DEPTH_W) begin
      rd_sum = rd_sum - DEPTH_W;
    end
    rd_ptr_next = rd_sum[AW-1:0];
    wr_ptr_next = wr_ptr;
    if (accept) begin
      wr_ptr_next = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_ONE;
    end
    count_next = count + CW'(accept) - CW'(eff_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      rd_ptr    <= rd_ptr_next;
      wr_ptr    <= wr_ptr_next;
      count     <= count_next;
      frame_err <= stop_bad;
      overflow  <= wr_en && !accept;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= shift_reg;
    end
  end

  // Lane k shows the k-th oldest byte; lanes beyond can_pop read as zero.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [AW:0] lane_idx;
      always_comb begin
        lane_idx = {1'b0, rd_ptr} + (AW + 1)'(gi);
        if (lane_idx >= DEPTH_W) begin
          lane_idx = lane_idx - DEPTH_W;
        end
        data_o[gi] = (PW'(gi) < can_pop) ? mem[lane_idx[AW-1:0]] : 8'h00;
      end
    end
  endgenerate

endmodule

// File: tb/tb_uart_rx_module.sv
// Randomised self-checking bench for uart_rx_module, using a byte-queue
// reference model and a bit-level line driver at a reduced bit period.
`timescale 1ns/1ps
module tb_uart_rx_module;

  localparam int BAUD  = 100_000;
  localparam int CLKF  = 1_600_000;
  localparam int DEPTH = 8;
  localparam int N     = 8;
  localparam int PW    = $clog2(N + 1);
  localparam int BIT   = CLKF / BAUD;
  localparam int HALF  = BIT / 2;
  // rx fall -> 2-cycle synchronizer -> half bit -> 9 bits -> visible next cycle
  localparam int LAT   = 2 + HALF + 9 * BIT + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx;
  logic [N-1:0][7:0] data_o;
  logic [PW-1:0]     pop;
  logic [PW-1:0]     can_pop;
  logic              frame_err;
  logic              overflow;

  uart_rx_module #(
    .boadrate(BAUD),
    .CLK_FREQ(CLKF),
    .DEPTH(DEPTH),
    .N(N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .data_o(data_o),
    .pop(pop),
    .can_pop(can_pop),
    .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int ov_cyc = 0;
  int rise_cyc = -1;
  int prev_cp = 0;
  int fall_cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [7:0] q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overflow) begin
      ov_cnt++;
      ov_cyc = cyc;
    end
    if (can_pop != 0 && prev_cp == 0) rise_cyc = cyc;
    prev_cp = int'(can_pop);
  end

  // ---------------------------------------------------------------- model
  function automatic int model_can();
    return (q.size() < N) ? q.size() : N;
  endfunction

  function automatic void model_pop(input int p);
    int e;
    e = p;
    if (e > model_can()) e = model_can();
    repeat (e) void'(q.pop_front());
  endfunction

  // Returns 1 when the byte is dropped.
  function automatic int model_write(input logic [7:0] b);
    if (q.size() < DEPTH) begin
      q.push_back(b);
      return 0;
    end
    return 1;
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int stop_bits,
                            input int idle_bits, input int pop_at_write);
    int total;
    int slot;
    fall_cyc = cyc;
    total = (9 + stop_bits + idle_bits) * BIT;
    for (int c = 0; c < total; c++) begin
      slot = c / BIT;
      if (slot == 0) rx = 1'b0;
      else if (slot <= 8) rx = b[slot-1];
      else if (slot < 9 + stop_bits) rx = stop_lvl;
      else rx = 1'b1;
      if (pop_at_write != 0) begin
        if (c == LAT - 1) pop = PW'(pop_at_write);
        else if (c == LAT) pop = '0;
      end
      tick();
    end
    $display("frame 0x%02h stop=%0d pop_at_write=%0d can_pop=%0d", b, stop_lvl, pop_at_write, can_pop);
  endtask

  task automatic do_pop(input int p);
    pop = PW'(p);
    tick();
    pop = '0;
    model_pop(p);
    $display("pop %0d -> can_pop=%0d", p, can_pop);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    pop = '0;
    repeat (3) tick();
    checks++;
    if (can_pop !== '0 || data_o !== '0 || frame_err !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs can_pop=%0d data=%h fe=%b ov=%b required all 0",
               can_pop, data_o, frame_err, overflow);
    end
    rst = 1'b0;
    repeat (2 * BIT) tick();
    $display("reset released");
  endtask

  task automatic test_single();
    void'(model_write(8'hA5));
    send_frame(8'hA5, 1'b1, 1, 1, 0);
    checks++;
    if (rise_cyc - fall_cyc != LAT) begin
      errors++;
      $display("FAIL single_latency got %0d required %0d", rise_cyc - fall_cyc, LAT);
    end
    checks++;
    if (can_pop !== PW'(1)) begin
      errors++;
      $display("FAIL single_can_pop got %0d required 1", can_pop);
    end
    for (int k = 0; k < N; k++) begin
      logic [7:0] exp;
      exp = (k < q.size()) ? q[k] : 8'h00;
      checks++;
      if (data_o[k] !== exp) begin
        errors++;
        $display("FAIL single_lane%0d got %h required %h", k, data_o[k], exp);
      end
    end
    do_pop(1);
    checks++;
    if (can_pop !== '0) begin
      errors++;
      $display("FAIL single_after_pop got %0d required 0", can_pop);
    end
  endtask

  task automatic test_burst();
    for (int i = 1; i <= 8; i++) begin
      void'(model_write(8'(i)));
      send_frame(8'(i), 1'b1, 1, (i == 8) ? 1 : 0, 0);
    end
    checks++;
    if (can_pop !== PW'(8)) begin
      errors++;
      $display("FAIL burst_can_pop got %0d required 8", can_pop);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (data_o[k] !== 8'(k + 1)) begin
        errors++;
        $display("FAIL burst_lane%0d got %h required %h", k, data_o[k], 8'(k + 1));
      end
    end
    do_pop(3);
    checks++;
    if (can_pop !== PW'(5) || data_o[0] !== 8'h04) begin
      errors++;
      $display("FAIL burst_pop3 can_pop=%0d lane0=%h required 5 and 04", can_pop, data_o[0]);
    end
    for (int k = 0; k < N; k++) begin
      logic [7:0] exp;
      exp = (k < q.size()) ? q[k] : 8'h00;
      checks++;
      if (data_o[k] !== exp) begin
        errors++;
        $display("FAIL burst_window%0d got %h required %h", k, data_o[k], exp);
      end
    end
    do_pop(7);
    checks++;
    if (can_pop !== '0 || data_o !== '0) begin
      errors++;
      $display("FAIL burst_clamped_pop can_pop=%0d data=%h required 0", can_pop, data_o);
    end
  endtask

  task automatic test_overflow();
    int ov0;
    ov0 = ov_cnt;
    for (int i = 0; i < 9; i++) begin
      void'(model_write(8'h10 + 8'(i)));
      send_frame(8'h10 + 8'(i), 1'b1, 1, (i == 8) ? 1 : 0, 0);
    end
    checks++;
    if (ov_cnt - ov0 != 1) begin
      errors++;
      $display("FAIL overflow_pulses got %0d required 1", ov_cnt - ov0);
    end
    checks++;
    if (ov_cyc - fall_cyc != LAT) begin
      errors++;
      $display("FAIL overflow_timing got %0d required %0d", ov_cyc - fall_cyc, LAT);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (data_o[k] !== q[k]) begin
        errors++;
        $display("FAIL overflow_lane%0d got %h required %h", k, data_o[k], q[k]);
      end
    end
    do_pop(N);
    ov0 = ov_cnt;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) model_pop(1);
      void'(model_write(8'h10 + 8'(i)));
      send_frame(8'h10 + 8'(i), 1'b1, 1, (i == 8) ? 1 : 0, (i == 8) ? 1 : 0);
    end
    checks++;
    if (ov_cnt != ov0) begin
      errors++;
      $display("FAIL overflow_pop_same_cycle pulses got %0d required 0", ov_cnt - ov0);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (data_o[k] !== 8'h11 + 8'(k) || data_o[k] !== q[k]) begin
        errors++;
        $display("FAIL overflow_pop_lane%0d got %h required %h", k, data_o[k], 8'h11 + 8'(k));
      end
    end
    do_pop(N);
  endtask

  task automatic test_frame_err();
    int fe0;
    int ov0;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(8'h3C, 1'b0, 2, 1, 0);
    checks++;
    if (fe_cnt - fe0 != 1 || can_pop !== PW'(model_can())) begin
      errors++;
      $display("FAIL frame_err pulses=%0d can_pop=%0d required 1 and %0d",
               fe_cnt - fe0, can_pop, model_can());
    end
    void'(model_write(8'h5A));
    send_frame(8'h5A, 1'b1, 1, 1, 0);
    checks++;
    if (can_pop !== PW'(1) || data_o[0] !== 8'h5A || ov_cnt != ov0 || fe_cnt - fe0 != 1) begin
      errors++;
      $display("FAIL frame_err_recovery can_pop=%0d lane0=%h required 1 and 5a", can_pop, data_o[0]);
    end
  endtask

  task automatic test_glitch();
    int fe0;
    int ov0;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rx = 1'b0;
    repeat (HALF - 3) tick();
    rx = 1'b1;
    repeat (12 * BIT) tick();
    $display("glitch of %0d cycles", HALF - 3);
    checks++;
    if (can_pop !== PW'(model_can()) || fe_cnt != fe0 || ov_cnt != ov0 || data_o[0] !== q[0]) begin
      errors++;
      $display("FAIL glitch can_pop=%0d fe=%0d ov=%0d required %0d 0 0",
               can_pop, fe_cnt - fe0, ov_cnt - ov0, model_can());
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 14; t++) begin
      logic [7:0] b;
      int p;
      int paw;
      int exp_drop;
      int ov0;
      b   = 8'($urandom_range(0, 255));
      p   = $urandom_range(0, 15);
      paw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, N) : 0;
      if ($urandom_range(0, 1) == 1) do_pop(p);
      ov0 = ov_cnt;
      model_pop(paw);
      exp_drop = model_write(b);
      send_frame(b, 1'b1, 1, 1, paw);
      checks++;
      if (ov_cnt - ov0 != exp_drop || can_pop !== PW'(model_can())) begin
        errors++;
        $display("FAIL random%0d ov=%0d can_pop=%0d required %0d %0d",
                 t, ov_cnt - ov0, can_pop, exp_drop, model_can());
      end
      for (int k = 0; k < N; k++) begin
        logic [7:0] exp;
        exp = (k < q.size()) ? q[k] : 8'h00;
        checks++;
        if (data_o[k] !== exp) begin
          errors++;
          $display("FAIL random%0d_lane%0d got %h required %h", t, k, data_o[k], exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [8];
    int fe0;
    int ov0;
    seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40};
    do_pop(N);
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    for (int i = 0; i < 8; i++) begin
      void'(model_write(seq[i]));
      send_frame(seq[i], 1'b1, 1, (i == 7) ? 1 : 0, 0);
    end
    checks++;
    if (can_pop !== PW'(8) || fe_cnt != fe0 || ov_cnt != ov0) begin
      errors++;
      $display("FAIL stream can_pop=%0d fe=%0d ov=%0d required 8 0 0",
               can_pop, fe_cnt - fe0, ov_cnt - ov0);
    end
    for (int k = 0; k < N; k++) begin
      checks++;
      if (data_o[k] !== seq[k]) begin
        errors++;
        $display("FAIL stream_lane%0d got %h required %h", k, data_o[k], seq[k]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    int fe0;
    b = 8'h96;
    for (int c = 0; c < 5 * BIT + HALF; c++) begin
      rx = (c < BIT) ? 1'b0 : b[c/BIT-1];
      tick();
    end
    #2 rst = 1'b1;
    #1;
    $display("reset asserted mid data bit 4");
    checks++;
    if (can_pop !== '0 || data_o !== '0 || frame_err !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset can_pop=%0d data=%h fe=%b ov=%b required all 0",
               can_pop, data_o, frame_err, overflow);
    end
    q.delete();
    rx = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    fe0 = fe_cnt;
    repeat (12 * BIT) tick();
    rx = 1'b1;
    repeat (2 * BIT) tick();
    checks++;
    if (can_pop !== '0 || fe_cnt != fe0) begin
      errors++;
      $display("FAIL low_line_after_reset can_pop=%0d fe=%0d required 0 0", can_pop, fe_cnt - fe0);
    end
    void'(model_write(8'hC3));
    send_frame(8'hC3, 1'b1, 1, 1, 0);
    checks++;
    if (can_pop !== PW'(1) || data_o[0] !== 8'hC3 || data_o[1] !== 8'h00) begin
      errors++;
      $display("FAIL after_reset_rx can_pop=%0d lane0=%h lane1=%h required 1 c3 00",
               can_pop, data_o[0], data_o[1]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_frame_err();
    test_glitch();
    test_random();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_module.md
# uart_rx_module

Serial UART receiver with a multi-byte pop interface. It samples an 8N1 asynchronous line and stores received bytes in an internal FIFO. It presents up to N oldest bytes at once, so a consumer can drain several bytes in one cycle. It sits directly downstream of `uart_tx_module`, whose `tx` drives this block's `rx` in loopback, and it mirrors that module's `push`/`can_push` convention as `pop`/`can_pop`.

## Interface
- `boadrate`, 115200, line bit rate in bit/s.
- `CLK_FREQ`, 50_000_000, `clk` frequency in Hz.
  - `BIT_CYC` = CLK_FREQ/boadrate, integer division (434 at defaults).
  - `HALF_CYC` = BIT_CYC/2 (217 at defaults).
- `DEPTH`, 8, FIFO capacity in bytes. DEPTH ≥ N is required.
- `N`, 8, maximum number of bytes presented and popped per cycle.
- `clk`  in  1  single system clock, all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial input, idle high, asynchronous to `clk`.
- `data_o`  out  [N-1:0][7:0]  FIFO window.
  - `data_o[0]` is the oldest byte.
  - `data_o[k]` is valid for k < `can_pop`; other lanes are driven 0.
- `pop`  in  $clog2(N+1)  number of bytes to remove this cycle.
- `can_pop`  out  $clog2(N+1)  equals min(FIFO count, N).
- `frame_err`  out  1  one-cycle pulse when a stop bit is sampled low.
- `overflow`  out  1  one-cycle pulse when a byte is dropped because the FIFO is full.

## Operation
- **Input synchronizer:** `rx` passes through a 2-FF synchronizer that resets to 1. All references to rx below mean the synchronized signal `rx_s`.
- **FSM:** states IDLE, START, DATA, STOP, WAIT_IDLE. A single bit counter is reloaded on every transition.
  - IDLE: a 1→0 edge on `rx_s` goes to START and loads HALF_CYC.
  - START: when the counter expires, sample `rx_s`.
    - Sample is 0: go to DATA and load BIT_CYC.
    - Sample is 1 (glitch): return to IDLE. No output.
  - DATA: sample once per BIT_CYC, 8 bits, LSB first, shifted into the shift register. After bit 7, go to STOP.
  - STOP: sample after BIT_CYC.
    - Sample is 1: write the byte to the FIFO and go to IDLE.
    - Sample is 0: pulse `frame_err`, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s` is 1, then go to IDLE.
- **FIFO:** circular buffer of DEPTH bytes with read/write pointers and a count of width $clog2(DEPTH+1). Pointers wrap modulo DEPTH.
  - `data_o[k]` = mem[(rd_ptr+k) mod DEPTH], masked to 0 when k ≥ `can_pop`. This path is combinational from the registers.
  - The effective pop is min(`pop`, `can_pop`). A request larger than `can_pop` is clamped, never treated as an error.
  - A write is accepted when count − effective_pop < DEPTH, so a pop in the same cycle frees space for the write.
  - A write that is not accepted drops the byte and pulses `overflow`. The FIFO contents are unchanged.
  - Same-cycle write and pop: count_next = count + write − effective_pop.
- **Reset:** `rst` may assert at any time, including mid-frame. It acts immediately and sets:
  - FSM to IDLE, with counter, shift register and pointers cleared;
  - count = 0 and synchronizer = 1;
  - outputs: `can_pop` = 0, `data_o` = 0, `frame_err` = 0, `overflow` = 0.
- After reset release, a line that is already low does not start a frame. Reception needs a 1→0 edge.

## Timing
- Let t0 be the first cycle in which `rx_s` = 0, which is 2 cycles after `rx` falls.
  - Start-bit check at t0 + HALF_CYC.
  - Data bit i (i = 0..7) sampled at t0 + HALF_CYC + (i+1)·BIT_CYC.
  - Stop bit sampled at t0 + HALF_CYC + 9·BIT_CYC, which is t0 + 4123 at defaults.
- The FIFO write is registered on the stop-sample edge. `can_pop` and `data_o` reflect the new byte in the next cycle.
- `frame_err` and `overflow` are registered. Each is high exactly one cycle, the cycle after the stop sample.
- `pop` acts on the posedge where it is sampled. `can_pop` and `data_o` reflect the removal in the next cycle.
- Back-to-back frames are supported. IDLE can detect the next start edge one cycle after the stop sample.
- Tolerated baud mismatch is about ±4%. Mid-bit sampling is the only sampling; there is no majority vote.

## Test plan
- **Single byte:** send 0xA5 at 115200 with `pop` = 0.
  - `can_pop` goes 0→1 at t0 + 4124.
  - `data_o[0]` = 0xA5 and `data_o[1..7]` = 0.
  - Then `pop` = 1 for one cycle makes `can_pop` = 0.
- **Burst with multi-pop:** send 0x01..0x08 back-to-back.
  - Expect `can_pop` = 8 and `data_o[k]` = k+1.
  - `pop` = 3 gives `can_pop` = 5 and `data_o[0]` = 0x04.
  - `pop` = 7 (clamped) gives `can_pop` = 0.
- **Overflow:** DEPTH = 8, send 9 bytes 0x10..0x18 with no pop.
  - `overflow` pulses once, one cycle after the 9th stop sample.
  - The FIFO holds 0x10..0x17.
  - Repeat with `pop` = 1 asserted in the 9th byte's write cycle: no `overflow`, and the FIFO ends with 0x11..0x18.
- **Frame error:** send 0x3C with the stop bit forced low for 2 bit times.
  - `frame_err` pulses once and `can_pop` is unchanged.
  - A following valid 0x5A is received correctly.
- **Glitch and reset:**
  - A 2 µs low pulse on `rx` produces no byte and no pulses.
  - Asserting `rst` during data bit 4 clears all outputs immediately.
  - After release, a subsequent 0xC3 is received correctly.
- **Loopback with `uart_tx_module`** (same `boadrate`, DEPTH, N):
  - Push 8 bytes {0x01,0x02,0x03,0x04,0x10,0x20,0x30,0x40} into the transmitter.
  - The receiver ends with `can_pop` = 8 and the bytes in the order the transmitter emits them.
  - No `frame_err` and no `overflow`.
